clk_div_bank: RTL

Parametrised bank of NCH independent clock dividers / tick generators, each with a runtime-programmable divisor. Each channel produces a one-cycle `tick` strobe every D cycles and a square-wave `out_clk` toggling on every tick (period 2·D). It feeds the slow-rate logic, such as display scan, debounce and seven-segment multiplexing, from the single board clock. Divisor changes are glitch-free, committed only at each channel's period boundary.

---
 rtl/clk_div_bank.sv | 107 ++++++++++
 1 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank
//   Bank of NCH independent tick generators / clock dividers. Each channel
//   has its own runtime-programmable divisor D. It emits a one-cycle `tick`
//   every D enabled cycles and a square wave `out_clk` that toggles on every
//   tick, giving a period of 2*D. A new divisor is staged in a shadow
//   register and takes effect only where the count restarts. Those points
//   are a wrap, a sync, or a stopped (D=0) channel, so a period is never cut
//   short.
//
// Ports
//   clk       in   board clock, rising-edge active
//   rst       in   asynchronous active-low reset
//   en        in   global count enable (0 freezes cnt/out_clk/D)
//   sync      in   synchronous restart of every channel, overrides en
//   div_ld    in   strobe: capture div_in into all shadow divisors
//   div_in    in   NCH*W packed divisors, channel i at [i*W +: W]
//   tick      out  per-channel one-cycle strobe (registered)
//   out_clk   out  per-channel divided square wave (registered)
//   div_pend  out  per-channel "shadow loaded, not yet committed"
module clk_div_bank #(
    parameter int          NCH      = 2,
    parameter int          W        = 25,
    parameter int unsigned DIV_INIT = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             div_ld,
    input  logic [NCH*W-1:0] div_in,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   out_clk,
    output logic [NCH-1:0]   div_pend
);

    localparam logic [W-1:0] DIV_RST = W'(DIV_INIT);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0] cnt;
        logic [W-1:0] div;
        logic [W-1:0] shadow;
        logic         pend;
        logic         tick_r;
        logic         out_r;
        logic         wrap;
        logic         commit;

        // A wrap is the last cycle of a period. A commit is any edge where
        // the count restarts from zero, which is the only safe place to swap
        // in a new divisor.
        always_comb begin
            wrap   = (div != '0) && (cnt == div - W'(1));
            commit = sync || (en && ((div == '0) || wrap));
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt    <= '0;
                div    <= DIV_RST;
                shadow <= DIV_RST;
                pend   <= 1'b0;
                tick_r <= 1'b0;
                out_r  <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments let the commit below use the
                // old shadow while the same edge's div_ld writes the new one.
                if (sync) begin
                    cnt    <= '0;
                    tick_r <= 1'b0;
                    out_r  <= 1'b0;
                end else if (en) begin
                    if (div == '0) begin
                        cnt    <= '0;
                        tick_r <= 1'b0;
                        out_r  <= 1'b0;
                    end else if (wrap) begin
                        cnt    <= '0;
                        tick_r <= 1'b1;
                        out_r  <= ~out_r;
                    end else begin
                        cnt    <= cnt + W'(1);
                        tick_r <= 1'b0;
                    end
                end else begin
                    tick_r <= 1'b0;
                end

                if (commit && pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end

                // A load on a commit edge re-arms pend. That write comes last
                // so it wins over the clear above.
                if (div_ld) begin
                    shadow <= div_in[i*W +: W];
                    pend   <= 1'b1;
                end
            end
        end

        assign tick[i]     = tick_r;
        assign out_clk[i]  = out_r;
        assign div_pend[i] = pend;
    end

endmodule
